// File: rtl/tvip_axi_read_responder.sv
// tvip_axi_read_responder
//   AXI4 read-channel slave that serves one AR request at a time.
//   The first R beat follows the AR handshake after READ_LATENCY cycles.
//   Beat data is derived from the beat address. Responses are OKAY, SLVERR
//   for malformed bursts, or DECERR for beats that fall outside the window.
// Ports:
//   aclk, areset              clock, asynchronous active-high reset
//   arvalid/arready/ar*       AR channel (arcache/arprot/arqos are ignored)
//   rvalid/rready/rid/rdata/rresp/rlast   R channel
module tvip_axi_read_responder #(
  parameter int          ID_WIDTH      = 4,
  parameter int          ADDRESS_WIDTH = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [63:0] BASE_ADDRESS  = 64'h0,
  parameter logic [63:0] SIZE_BYTES    = 64'd4096,
  parameter int          READ_LATENCY  = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ID_WIDTH-1:0]      arid,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic [3:0]               arcache,
  input  logic [2:0]               arprot,
  input  logic [3:0]               arqos,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [ID_WIDTH-1:0]      rid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rlast
);
  localparam int AW  = ADDRESS_WIDTH;
  localparam int BPB = DATA_WIDTH / 8;
  localparam int NL  = DATA_WIDTH / 32;
  localparam int LG_BPB = $clog2(BPB);
  localparam int CW  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [AW-1:0] BASE_A   = BASE_ADDRESS[AW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_e;

  state_e          state_q, state_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [CW-1:0]   cnt_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [AW-1:0]   start_q, addr_q, addr_nxt;
  logic [7:0]      len_q, beat_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic            err_q;

  logic ar_hs, r_hs, last_hs, ar_err, in_win, ok_beat;
  logic [AW-1:0] ar_bsz, bsz, wlen, lower, inc, wbase;

  // AXI sideband fields that this target does not act on.
  logic unused_sideband;
  assign unused_sideband = ^{arcache, arprot, arqos};

  assign ar_hs   = arvalid & arready_q;
  assign r_hs    = rvalid_q & rready;
  assign last_hs = r_hs & (beat_q == len_q);

  // Burst-level legality, evaluated on the incoming request and latched.
  assign ar_bsz = AW'(1) << arsize;
  assign ar_err = (arburst == 2'b11)
               || (int'(arsize) > LG_BPB)
               || ((arburst == 2'b10) && !((arlen == 8'd1) || (arlen == 8'd3) ||
                                           (arlen == 8'd7) || (arlen == 8'd15)))
               || ((arburst == 2'b10) && ((araddr & (ar_bsz - AW'(1))) != '0));

  // ---- FSM: state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ar_hs) state_d = (READ_LATENCY > 1) ? S_WAIT : S_DATA;
      S_WAIT: if (cnt_q == '0) state_d = S_DATA;
      S_DATA: if (last_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM: outputs (registered). rvalid lags entry into DATA by one edge,
  // which is what gives exactly READ_LATENCY edges from AR to first beat.
  always_comb begin
    arready_d = (state_d == S_IDLE);
    rvalid_d  = (state_q == S_DATA) && !last_hs;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // ---- Request capture, latency counter, beat sequencing
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q   <= '0;
      id_q    <= '0;
      start_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (ar_hs) begin
        cnt_q   <= CNT_LOAD;
        id_q    <= arid;
        start_q <= araddr;
        addr_q  <= araddr;
        len_q   <= arlen;
        beat_q  <= '0;
        size_q  <= arsize;
        burst_q <= arburst;
        err_q   <= ar_err;
      end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (r_hs) begin
        addr_q <= addr_nxt;
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  // ---- Next beat address
  always_comb begin
    bsz   = AW'(1) << size_q;
    wlen  = (AW'(len_q) + AW'(1)) * bsz;
    lower = start_q & ~(wlen - AW'(1));
    inc   = addr_q + bsz;
    case (burst_q)
      2'b01:   addr_nxt = (addr_q & ~(bsz - AW'(1))) + bsz;
      2'b10:   addr_nxt = (inc == lower + wlen) ? lower : inc;
      default: addr_nxt = addr_q;
    endcase
  end

  // ---- Beat response. Outputs are zero whenever rvalid is low, so reset
  // clears them immediately through rvalid_q.
  assign in_win  = (64'(addr_q - BASE_A) < SIZE_BYTES);
  assign ok_beat = rvalid_q & ~err_q & in_win;
  assign wbase   = addr_q & ~AW'(BPB - 1);

  for (genvar k = 0; k < NL; k++) begin : g_lane
    assign rdata[32*k +: 32] = ok_beat ? 32'(wbase + AW'(4 * k)) : 32'h0;
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rvalid_q ? id_q : '0;
  assign rlast   = rvalid_q & (beat_q == len_q);
  assign rresp   = !rvalid_q ? 2'b00 :
                   err_q     ? 2'b10 :
                   !in_win   ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_tvip_axi_read_responder.sv
// Directed bench for tvip_axi_read_responder with default parameters
// (32-bit data, 4 KB window at 0, latency 2).
module tb_tvip_axi_read_responder;
  localparam int LAT = 2;
  localparam logic [1:0] OK = 2'b00, SLV = 2'b10, DEC = 2'b11;
  localparam logic [1:0] FIX = 2'b00, INC = 2'b01, WRP = 2'b10, RSV = 2'b11;

  logic        aclk, areset;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_d [256];
  logic [1:0]  exp_r [256];

  tvip_axi_read_responder dut (
    .aclk(aclk), .areset(areset),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int n, input logic [31:0] d0, input logic [31:0] step,
                      input logic [1:0] r);
    for (int i = 0; i < n; i++) begin
      exp_d[i] = d0 + step * i;
      exp_r[i] = r;
    end
  endtask

  // Issue one AR at a negedge and measure edges until rvalid.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int g = 0;
    int lat = 0;
    while (!arready && g < 50) begin @(negedge aclk); g++; end
    chk("ar_ready_wait", arready, 1);
    arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    @(posedge aclk); @(negedge aclk);
    arvalid = 0;
    chk("ar_ready_drop", arready, 0);
    while (!rvalid && lat < 50) begin @(posedge aclk); @(negedge aclk); lat++; end
    chk("ar_latency", lat, LAT);
  endtask

  // Consume 'take' of 'nb' beats; optional random rready stalls.
  task automatic recv(input int nb, input int take, input bit stall, input logic [3:0] id);
    int i = 0;
    int g = 0;
    bit held = 0;
    logic [31:0] hd;
    logic [1:0]  hr;
    logic        hl;
    while (i < take && g < 1000) begin
      g++;
      if (!rvalid) begin
        chk("rvalid_gap", rvalid, 1);
        break;
      end
      if (held) begin
        chk("hold_data", rdata, hd);
        chk("hold_resp", rresp, hr);
        chk("hold_last", rlast, hl);
      end
      if (stall && $urandom_range(0, 2) == 0) begin
        rready = 0; held = 1; hd = rdata; hr = rresp; hl = rlast;
      end else begin
        rready = 1; held = 0;
        chk("beat_data", rdata, exp_d[i]);
        chk("beat_resp", rresp, exp_r[i]);
        chk("beat_last", rlast, (i == nb - 1));
        chk("beat_id", rid, id);
        chk("arready_busy", arready, 0);
        i++;
      end
      @(posedge aclk); @(negedge aclk);
    end
    rready = 0;
    chk("beat_count", i, take);
    if (take == nb) begin
      chk("rvalid_end", rvalid, 0);
      chk("arready_end", arready, 1);
    end
  endtask

  task automatic run(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                     input logic [2:0] size, input logic [1:0] burst, input bit stall);
    send_ar(id, addr, len, size, burst);
    recv(int'(len) + 1, int'(len) + 1, stall, id);
  endtask

  initial begin
    areset = 1; arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    arcache = 0; arprot = 0; arqos = 0; rready = 0;
    repeat (2) @(negedge aclk);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    areset = 0;
    #1 chk("arready_pre_edge", arready, 0);
    @(negedge aclk);
    chk("arready_after_rel", arready, 1);

    // INCR 4 beats
    fill(4, 32'h100, 4, OK);
    run(4'h5, 32'h100, 3, 2, INC, 0);

    // WRAP 4 beats starting mid-window
    fill(4, 0, 0, OK);
    exp_d[0] = 32'h108; exp_d[1] = 32'h10C; exp_d[2] = 32'h100; exp_d[3] = 32'h104;
    run(4'hA, 32'h108, 3, 2, WRP, 0);

    // FIXED
    fill(3, 32'h20, 0, OK);
    run(4'h1, 32'h20, 2, 2, FIX, 0);

    // INCR byte beats, unaligned start
    fill(4, 32'h100, 0, OK);
    exp_d[3] = 32'h104;
    run(4'h2, 32'h101, 3, 0, INC, 0);

    // Crossing the top of the window
    exp_d[0] = 32'hFFC; exp_r[0] = OK;
    exp_d[1] = 32'h0;   exp_r[1] = DEC;
    run(4'h3, 32'hFFC, 1, 2, INC, 0);

    // Illegal WRAP length, reserved burst type
    fill(3, 0, 0, SLV);
    run(4'h4, 32'h100, 2, 2, WRP, 0);
    run(4'h6, 32'h100, 2, 2, RSV, 0);

    // Beat wider than the bus
    fill(1, 0, 0, SLV);
    run(4'h7, 32'h100, 0, 3, INC, 0);

    // SLVERR wins over DECERR
    run(4'h8, 32'h2000, 0, 2, RSV, 0);

    // Out-of-window single beat
    fill(1, 0, 0, DEC);
    run(4'h9, 32'h2000, 0, 2, INC, 0);

    // WRAP with a misaligned start
    fill(2, 0, 0, SLV);
    run(4'hB, 32'h102, 1, 2, WRP, 0);

    // 16 beats under random backpressure
    fill(16, 32'h200, 4, OK);
    run(4'hC, 32'h200, 15, 2, INC, 1);

    // Reset in the middle of a burst
    fill(16, 32'h300, 4, OK);
    send_ar(4'hD, 32'h300, 15, 2, INC);
    recv(16, 4, 0, 4'hD);
    areset = 1;
    #1;
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_arready", arready, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_rlast", rlast, 0);
    @(negedge aclk);
    areset = 0;
    #1 chk("midrst_arready_hold", arready, 0);
    @(negedge aclk);
    chk("midrst_arready_up", arready, 1);

    // Service resumes normally
    fill(2, 32'h40, 4, OK);
    run(4'hE, 32'h40, 1, 2, INC, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
